// File: rtl/pipe_issuer.sv
// Issues operand pairs into a fixed-latency external pipeline and buffers its results in an in-order FIFO.
// Optional result self-check is enabled by defining PIPE_ISSUER_CHECK_EN.
module pipe_issuer #(
  parameter int DWIDTH  = 8,
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DWIDTH-1:0] op1_i,
  input  logic [DWIDTH-1:0] op2_i,
  output logic [DWIDTH-1:0] pipe_op1_o,
  output logic [DWIDTH-1:0] pipe_op2_o,
  input  logic [DWIDTH-1:0] pipe_res_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DWIDTH-1:0] out_res_o,
  output logic              out_err_o,
  output logic              idle_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(DEPTH + LATENCY + 1);

  logic [LATENCY-1:0] r_vld;
  logic [PW-1:0]      r_wr;
  logic [PW-1:0]      r_rd;
  logic [CW-1:0]      r_cnt;
  logic [DWIDTH-1:0]  r_mem [DEPTH];

  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic [SW-1:0] w_inflight;

  always_comb begin
    w_inflight = '0;
    for (int unsigned i = 0; i < LATENCY; i++) begin
      w_inflight = w_inflight + SW'(r_vld[i]);
    end
  end

  // Credit check uses registered occupancy only: a pop this cycle frees space next cycle.
  assign in_ready_o  = (SW'(r_cnt) + w_inflight) < SW'(DEPTH);
  assign w_accept    = in_valid_i & in_ready_o;
  assign w_push      = r_vld[LATENCY-1];
  assign out_valid_o = (r_cnt != '0);
  assign w_pop       = out_valid_o & out_ready_i;
  assign out_res_o   = out_valid_o ? r_mem[r_rd] : '0;
  assign idle_o      = (w_inflight == '0) && (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld      <= '0;
      pipe_op1_o <= '0;
      pipe_op2_o <= '0;
      r_wr       <= '0;
      r_rd       <= '0;
      r_cnt      <= '0;
    end else begin
      r_vld      <= (r_vld << 1) | LATENCY'(w_accept);
      pipe_op1_o <= w_accept ? op1_i : '0;
      pipe_op2_o <= w_accept ? op2_i : '0;
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= pipe_res_i;
  end

`ifdef PIPE_ISSUER_CHECK_EN
  logic [DWIDTH-1:0] r_exp [LATENCY];
  logic [DEPTH-1:0]  r_err_mem;

  // (op1+op2)-op1 reduces to op2 modulo 2^DWIDTH, so only op2 travels alongside the beat.
  always_ff @(posedge clk) begin
    r_exp[0] <= op2_i;
    for (int unsigned i = 1; i < LATENCY; i++) begin
      r_exp[i] <= r_exp[i-1];
    end
    if (w_push) r_err_mem[r_wr] <= (pipe_res_i != r_exp[LATENCY-1]);
  end

  assign out_err_o = out_valid_o & r_err_mem[r_rd];
`else
  assign out_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_issuer.sv
// Scoreboard bench for pipe_issuer with a one-register downstream pipeline model.
module tb_pipe_issuer;

  localparam int DW  = 8;
  localparam int LAT = 2;
  localparam int DEP = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] op1;
  logic [DW-1:0] op2;
  logic [DW-1:0] pipe_op1;
  logic [DW-1:0] pipe_op2;
  logic [DW-1:0] pipe_res = '0;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_res;
  logic          out_err;
  logic          idle;

  logic [DW:0] sb_q[$];
  int n_chk  = 0;
  int n_pass = 0;
  int n_pop  = 0;
  int cyc    = 0;
  logic last_acc;
  logic last_pop;

  always #5 clk = ~clk;

  pipe_issuer #(.DWIDTH(DW), .LATENCY(LAT), .DEPTH(DEP)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .op1_i      (op1),
    .op2_i      (op2),
    .pipe_op1_o (pipe_op1),
    .pipe_op2_o (pipe_op2),
    .pipe_res_i (pipe_res),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_res_o  (out_res),
    .out_err_o  (out_err),
    .idle_o     (idle)
  );

  // Downstream pipeline: returns (op1+op2)-op1, but corrupts the result for op2 == 8'h10.
  function automatic logic [DW-1:0] pipe_fn(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] s;
    s = a + b;
    s = s - a;
    return (b == 8'h10) ? 8'hFF : s;
  endfunction

  function automatic logic exp_err(input logic [DW-1:0] res, input logic [DW-1:0] b);
`ifdef PIPE_ISSUER_CHECK_EN
    return res != b;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk) pipe_res <= pipe_fn(pipe_op1, pipe_op2);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Sample 1ns after the negedge drive, score the coming edge, then return at the next negedge.
  task automatic tick();
    logic [DW:0]   e;
    logic [DW-1:0] r;
    #1;
    last_acc = !rst && in_valid && in_ready;
    last_pop = !rst && out_valid && out_ready;
    if (last_acc) begin
      r = pipe_fn(op1, op2);
      sb_q.push_back({exp_err(r, op2), r});
    end
    if (last_pop) begin
      n_pop++;
      if (sb_q.size() == 0) begin
        check("spurious_out", 32'(out_valid), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("out_res", 32'(out_res), 32'(e[DW-1:0]));
        check("out_err", 32'(out_err), 32'(e[DW]));
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, first, last, n0, idx, g, seen;
    rst = 1'b1; in_valid = 1'b0; op1 = '0; op2 = '0; out_ready = 1'b0;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_res",   32'(out_res),   32'd0);
    check("rst_out_err",   32'(out_err),   32'd0);
    check("rst_idle",      32'(idle),      32'd1);
    check("rst_pipe_op1",  32'(pipe_op1),  32'd0);

    // single beat
    op1 = 8'h05; op2 = 8'h03; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    check("single_acc", 32'(last_acc), 32'd1);
    in_valid = 1'b0;
    check("single_pipe_op1", 32'(pipe_op1), 32'h05);
    check("single_pipe_op2", 32'(pipe_op2), 32'h03);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!last_pop && lat < 12);
    check("single_latency",   32'(lat),       32'(LAT + 1));
    check("single_idle_after", 32'(idle),     32'd1);
    check("single_valid_after", 32'(out_valid), 32'd0);

    // 10-pair stream with consumer always ready
    first = -1; last = -1; n0 = n_pop;
    for (int i = 0; i < 10; i++) begin
      check("stream_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1; op1 = DW'($urandom); op2 = DW'(i * 7 + 1);
      tick();
      if (last_pop) begin if (first < 0) first = cyc; last = cyc; end
    end
    in_valid = 1'b0;
    g = 0;
    while (sb_q.size() != 0 && g < 20) begin
      tick();
      if (last_pop) begin if (first < 0) first = cyc; last = cyc; end
      g++;
    end
    check("stream_pops", 32'(n_pop - n0), 32'd10);
    check("stream_span", 32'(last - first), 32'd9);

    // backpressure: only DEPTH pairs fit while the consumer stalls
    out_ready = 1'b0; idx = 0;
    for (int t = 0; t < 8; t++) begin
      in_valid = 1'b1; op1 = DW'(idx); op2 = DW'(8'h40 + idx);
      tick();
      if (last_acc) idx++;
    end
    check("bp_accepts",   32'(idx),       32'd4);
    check("bp_ready_low", 32'(in_ready),  32'd0);
    check("bp_valid",     32'(out_valid), 32'd1);
    out_ready = 1'b1; g = 0;
    while ((idx < 6 || sb_q.size() != 0) && g < 40) begin
      in_valid = (idx < 6); op1 = DW'(idx); op2 = DW'(8'h40 + idx);
      tick();
      if (last_acc) idx++;
      g++;
    end
    in_valid = 1'b0;
    check("bp_all_accepted", 32'(idx),         32'd6);
    check("bp_drained",      32'(sb_q.size()), 32'd0);

    // corrupted result surrounded by clean neighbours
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; op1 = 8'h22; op2 = DW'(8'h0F + i);
      tick();
    end
    in_valid = 1'b0;
    g = 0;
    while (sb_q.size() != 0 && g < 20) begin tick(); g++; end
    check("corrupt_drained", 32'(sb_q.size()), 32'd0);

    // reset with 2 results buffered and 2 in flight
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; op1 = DW'($urandom); op2 = DW'($urandom);
      tick();
      check("mid_acc", 32'(last_acc), 32'd1);
    end
    in_valid = 1'b0;
    check("mid_busy_valid", 32'(out_valid), 32'd1);
    check("mid_busy_idle",  32'(idle),      32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb_q.delete();
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_idle",  32'(idle),      32'd1);
    check("mid_rst_ready", 32'(in_ready),  32'd1);
    check("mid_rst_res",   32'(out_res),   32'd0);
    out_ready = 1'b1; seen = 0;
    repeat (10) begin
      seen += int'(out_valid);
      tick();
    end
    check("mid_rst_no_stale", 32'(seen), 32'd0);

    // fill, then stream through a saturated FIFO so pointers wrap several times
    out_ready = 1'b0; idx = 0;
    for (int t = 0; t < 7; t++) begin
      in_valid = (idx < 4); op1 = DW'($urandom); op2 = DW'($urandom);
      tick();
      if (last_acc) idx++;
    end
    check("wrap_fill",       32'(idx),      32'd4);
    check("wrap_full_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1; n0 = n_pop;
    for (int t = 0; t < 16; t++) begin
      check("wrap_ready", 32'(in_ready), 32'(t > 0));
      in_valid = (idx < 16); op1 = DW'($urandom); op2 = DW'($urandom);
      tick();
      if (last_acc) idx++;
    end
    in_valid = 1'b0;
    check("wrap_pops", 32'(n_pop - n0), 32'd16);
    check("wrap_idle", 32'(idle),       32'd1);

    // random consumer stalls
    idx = 0; g = 0;
    while ((idx < 24 || sb_q.size() != 0) && g < 300) begin
      in_valid = (idx < 24); op1 = DW'($urandom); op2 = DW'($urandom);
      out_ready = (idx >= 24) ? 1'b1 : 1'($urandom_range(0, 1));
      tick();
      if (last_acc) idx++;
      g++;
    end
    in_valid = 1'b0;
    check("rand_accepted", 32'(idx),         32'd24);
    check("rand_drained",  32'(sb_q.size()), 32'd0);
    tick();
    check("rand_idle",     32'(idle),        32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
